// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: control/redirect and imem write inputs, plus the IF/ID outputs.
// The master modport is the pipeline side; the fetch unit takes the slave modport.
interface instr_fetch_unit_if #(
    parameter int INSTR_WIDTH = 8,
    parameter int ADDR_WIDTH  = 8
);
    localparam int R = (INSTR_WIDTH - 2) / 2;

    logic                   stall;
    logic                   redirect_valid;
    logic [ADDR_WIDTH-1:0]  redirect_pc;
    logic                   imem_we;
    logic [ADDR_WIDTH-1:0]  imem_waddr;
    logic [INSTR_WIDTH-1:0] imem_wdata;

    logic [ADDR_WIDTH-1:0]  PC;
    logic                   instr_valid;
    logic [ADDR_WIDTH-1:0]  instr_pc;
    logic [INSTR_WIDTH-1:0] Instruction_Code;
    logic [1:0]             Opcode;
    logic [R-1:0]           Rd;
    logic [R-1:0]           Rs;
    logic [INSTR_WIDTH-3:0] Partial_Address;

    modport master (
        output stall, redirect_valid, redirect_pc, imem_we, imem_waddr, imem_wdata,
        input  PC, instr_valid, instr_pc, Instruction_Code, Opcode, Rd, Rs, Partial_Address
    );

    modport slave (
        input  stall, redirect_valid, redirect_pc, imem_we, imem_waddr, imem_wdata,
        output PC, instr_valid, instr_pc, Instruction_Code, Opcode, Rd, Rs, Partial_Address
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, writable instruction memory with combinational read,
// jump pre-decode for zero-bubble jumps, and the IF/ID register with stall/redirect.
module instr_fetch_unit #(
    parameter int                    INSTR_WIDTH = 8,
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    DEPTH       = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                clk,
    input  logic                reset,
    instr_fetch_unit_if.slave   bus
);
    localparam int P     = INSTR_WIDTH - 2;
    localparam int R     = P / 2;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    logic [INSTR_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0]  pc_reg;
    logic [ADDR_WIDTH-1:0]  pc_next;
    logic                   valid_reg;
    logic [ADDR_WIDTH-1:0]  instr_pc_reg;
    logic [INSTR_WIDTH-1:0] instr_reg;

    logic [INSTR_WIDTH-1:0] fetch_word;
    logic [ADDR_WIDTH-1:0]  jump_target;
    logic                   is_jump;
    logic                   pc_in_range;
    logic                   waddr_in_range;
    logic [IDX_W-1:0]       pc_idx;
    logic [IDX_W-1:0]       waddr_idx;

    assign pc_in_range    = {1'b0, pc_reg} < DEPTH_W;
    assign waddr_in_range = {1'b0, bus.imem_waddr} < DEPTH_W;
    assign pc_idx         = pc_reg[IDX_W-1:0];
    assign waddr_idx      = bus.imem_waddr[IDX_W-1:0];

    // Memory survives reset; out-of-range writes are dropped rather than aliased.
    always_ff @(posedge clk) begin
        if (bus.imem_we && waddr_in_range) begin
            mem[waddr_idx] <= bus.imem_wdata;
        end
    end

    // Unimplemented addresses fetch all-zero, which decodes as a NOP (mov R0,R0).
    assign fetch_word = pc_in_range ? mem[pc_idx] : '0;
    assign is_jump    = (fetch_word[INSTR_WIDTH-1:INSTR_WIDTH-2] == 2'b11);

    generate
        if (ADDR_WIDTH <= P) begin : g_jump_narrow
            assign jump_target = fetch_word[ADDR_WIDTH-1:0];
        end else begin : g_jump_wide
            // Jumps stay within the current PC-aligned page of 2^P words.
            assign jump_target = {pc_reg[ADDR_WIDTH-1:P], fetch_word[P-1:0]};
        end
    endgenerate

    always_comb begin
        pc_next = pc_reg + ADDR_WIDTH'(1);
        if (bus.redirect_valid) begin
            pc_next = bus.redirect_pc;
        end else if (bus.stall) begin
            pc_next = pc_reg;
        end else if (is_jump) begin
            pc_next = jump_target;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg       <= RESET_PC;
            valid_reg    <= 1'b0;
            instr_pc_reg <= '0;
            instr_reg    <= '0;
        end else begin
            pc_reg <= pc_next;
            if (bus.redirect_valid) begin
                valid_reg    <= 1'b0;
                instr_pc_reg <= '0;
                instr_reg    <= '0;
            end else if (!bus.stall) begin
                valid_reg    <= 1'b1;
                instr_pc_reg <= pc_reg;
                instr_reg    <= fetch_word;
            end
        end
    end

    assign bus.PC               = pc_reg;
    assign bus.instr_valid      = valid_reg;
    assign bus.instr_pc         = instr_pc_reg;
    assign bus.Instruction_Code = instr_reg;
    assign bus.Opcode           = instr_reg[INSTR_WIDTH-1:INSTR_WIDTH-2];
    assign bus.Rd               = instr_reg[2*R-1:R];
    assign bus.Rs               = instr_reg[R-1:0];
    assign bus.Partial_Address  = instr_reg[INSTR_WIDTH-3:0];
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a default 8/8/8 instance runs the jump,
// stall, redirect, range/wrap and reset scenarios; a 16/16 instance checks the page jump.
module tb_instr_fetch_unit;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.INSTR_WIDTH(8),  .ADDR_WIDTH(8))  bus ();
    instr_fetch_unit_if #(.INSTR_WIDTH(16), .ADDR_WIDTH(16)) wbus ();

    instr_fetch_unit #(
        .INSTR_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(8), .RESET_PC(8'd0)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    instr_fetch_unit #(
        .INSTR_WIDTH(16), .ADDR_WIDTH(16), .DEPTH(16392), .RESET_PC(16'd0)
    ) u_wide (
        .clk   (clk),
        .reset (reset),
        .bus   (wbus.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic v, input logic [7:0] pc,
                            input logic [7:0] code);
        check({tag, ".valid"}, 32'(bus.instr_valid), 32'(v));
        check({tag, ".instr_pc"}, 32'(bus.instr_pc), 32'(pc));
        check({tag, ".code"}, 32'(bus.Instruction_Code), 32'(code));
    endtask

    // One bubble through a redirect: the redirect edge, then drop redirect.
    task automatic redirect_to(input logic [7:0] target);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        tick();
        bus.redirect_valid = 1'b0;
    endtask

    logic [7:0] prog [6];

    initial begin
        prog[0] = 8'b00011011; prog[1] = 8'b01011011; prog[2] = 8'b01010011;
        prog[3] = 8'b11000101; prog[4] = 8'b00011010; prog[5] = 8'b01011010;

        bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
        bus.imem_we = 1'b0; bus.imem_waddr = '0; bus.imem_wdata = '0;
        wbus.stall = 1'b0; wbus.redirect_valid = 1'b0; wbus.redirect_pc = '0;
        wbus.imem_we = 1'b0; wbus.imem_waddr = '0; wbus.imem_wdata = '0;

        // Program loads while reset is held; memory is not cleared by reset.
        for (int i = 0; i < 6; i++) begin
            bus.imem_we = 1'b1; bus.imem_waddr = 8'(i); bus.imem_wdata = prog[i];
            tick();
        end
        bus.imem_we = 1'b0;
        wbus.imem_we = 1'b1; wbus.imem_waddr = 16'h4003; wbus.imem_wdata = 16'hC005;
        tick();
        wbus.imem_waddr = 16'h4005; wbus.imem_wdata = 16'h2AAA;
        tick();
        wbus.imem_we = 1'b0;
        check("rst.PC", 32'(bus.PC), 32'd0);
        chk_ifid("rst", 1'b0, 8'd0, 8'd0);

        reset = 1'b0;
        tick(); chk_ifid("pc0", 1'b1, 8'd0, prog[0]);
        tick(); chk_ifid("pc1", 1'b1, 8'd1, prog[1]);
        tick(); chk_ifid("pc2", 1'b1, 8'd2, prog[2]);

        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_ifid($sformatf("stall%0d", i), 1'b1, 8'd2, prog[2]);
            check($sformatf("stall%0d.PC", i), 32'(bus.PC), 32'd3);
        end
        bus.stall = 1'b0;
        tick(); chk_ifid("jmp", 1'b1, 8'd3, prog[3]);
        check("jmp.opcode", 32'(bus.Opcode), 32'd3);
        check("jmp.paddr", 32'(bus.Partial_Address), 32'b000101);
        check("jmp.PC", 32'(bus.PC), 32'd5);
        tick(); chk_ifid("pc5", 1'b1, 8'd5, prog[5]);
        check("pc5.rd", 32'(bus.Rd), 32'd3);
        check("pc5.rs", 32'(bus.Rs), 32'd2);

        // Redirect wins over a simultaneous stall.
        bus.stall = 1'b1;
        redirect_to(8'd4);
        bus.stall = 1'b0;
        chk_ifid("redir.bubble", 1'b0, 8'd0, 8'd0);
        check("redir.PC", 32'(bus.PC), 32'd4);
        tick(); chk_ifid("redir.pc4", 1'b1, 8'd4, prog[4]);
        check("redir.rd", 32'(bus.Rd), 32'd3);
        check("redir.rs", 32'(bus.Rs), 32'd2);

        redirect_to(8'd8);
        tick(); chk_ifid("range.pc8", 1'b1, 8'd8, 8'd0);

        redirect_to(8'd255);
        tick(); chk_ifid("wrap.pc255", 1'b1, 8'd255, 8'd0);
        check("wrap.PC", 32'(bus.PC), 32'd0);
        tick(); chk_ifid("wrap.pc0", 1'b1, 8'd0, prog[0]);

        // Write the word being fetched: old word now, new word on the refetch.
        redirect_to(8'd2);
        bus.imem_we = 1'b1; bus.imem_waddr = 8'd2; bus.imem_wdata = 8'h2A;
        tick(); chk_ifid("wr.old", 1'b1, 8'd2, prog[2]);
        bus.imem_we = 1'b0;
        redirect_to(8'd2);
        tick(); chk_ifid("wr.new", 1'b1, 8'd2, 8'h2A);

        // An out-of-range write must not alias onto address 1.
        bus.imem_we = 1'b1; bus.imem_waddr = 8'd9; bus.imem_wdata = 8'hFF;
        tick();
        bus.imem_we = 1'b0;
        redirect_to(8'd1);
        tick(); chk_ifid("oor.pc1", 1'b1, 8'd1, prog[1]);

        // Asynchronous reset between edges, while stalled.
        bus.stall = 1'b1;
        #3 reset = 1'b1;
        #1;
        check("arst.PC", 32'(bus.PC), 32'd0);
        chk_ifid("arst", 1'b0, 8'd0, 8'd0);
        tick();
        bus.stall = 1'b0;
        reset = 1'b0;
        tick(); chk_ifid("arst.resume", 1'b1, 8'd0, prog[0]);

        // Wide configuration: jump keeps the upper PC bits above Partial_Address.
        wbus.redirect_valid = 1'b1; wbus.redirect_pc = 16'h4003;
        tick();
        wbus.redirect_valid = 1'b0;
        tick();
        check("wide.jmp.pc", 32'(wbus.instr_pc), 32'h4003);
        check("wide.jmp.opcode", 32'(wbus.Opcode), 32'd3);
        check("wide.jmp.paddr", 32'(wbus.Partial_Address), 32'h0005);
        tick();
        check("wide.tgt.valid", 32'(wbus.instr_valid), 32'd1);
        check("wide.tgt.pc", 32'(wbus.instr_pc), 32'h4005);
        check("wide.tgt.rd", 32'(wbus.Rd), 32'h55);
        check("wide.tgt.rs", 32'(wbus.Rs), 32'h2A);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
